// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32I integer core: opcodes, funct3 codes, ALU ops, select enums.
// The optional debug writeback port on cpu is enabled with CPU_DEBUG_PORT_EN.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    typedef enum logic [1:0] {WB_ALU, WB_PC4, WB_LUI, WB_AUIPC} wb_sel_t;
    typedef enum logic [1:0] {PC_SEQ, PC_BR, PC_JAL, PC_JALR} pc_sel_t;

    // alt selects SUB/SRA (funct7 bit 5) for the shared OP/OP-IMM funct3 space
    function automatic alu_op_t alu_op_from_f3(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Integer ALU with independent branch comparator outputs.
module cpu_alu
    import cpu_pkg::*;
(
    input  alu_op_t     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        eq,
    output logic        lt,
    output logic        ltu
);

    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic        [4:0]  shamt;

    assign a_s   = a;
    assign b_s   = b;
    assign shamt = b[4:0];

    assign eq  = (a == b);
    assign lt  = (a_s < b_s);
    assign ltu = (a < b);

    always_comb begin
        result = 32'd0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << shamt;
            ALU_SLT:  result = {31'd0, lt};
            ALU_SLTU: result = {31'd0, ltu};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = 32'(a_s >>> shamt);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = 32'd0;
        endcase
    end

endmodule

// File: rtl/cpu.sv
// Single-issue RV32I subset core: decode, register file and PC; one instruction per fetch beat.
// Define CPU_DEBUG_PORT_EN to expose the retire/writeback debug port.
module cpu
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid_in,
    input  logic        instr_ready_in,
    input  logic [31:0] instr_in,
    output logic [31:0] instr_addr_out,
`ifdef CPU_DEBUG_PORT_EN
    output logic        dbg_wb_en,
    output logic [4:0]  dbg_wb_addr,
    output logic [31:0] dbg_wb_data,
    output logic        dbg_retire,
`endif
    output logic        instr_addr_valid_out
);

    logic [31:0] pc_q;
    logic        addr_vld_q;
    logic [31:0] rf [32];

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, pc_plus4;

    alu_op_t     alu_op;
    logic [31:0] alu_b, alu_result;
    logic        alu_eq, alu_lt, alu_ltu;
    logic        wb_en;
    wb_sel_t     wb_sel;
    pc_sel_t     pc_sel;
    logic        br_taken;
    logic [31:0] wb_data, next_pc;
    logic        fire, wb_write;

    assign fire     = addr_vld_q && instr_valid_in && instr_ready_in;
    assign pc_plus4 = pc_q + 32'd4;

    assign opcode = instr_in[6:0];
    assign rd     = instr_in[11:7];
    assign f3     = instr_in[14:12];
    assign rs1    = instr_in[19:15];
    assign rs2    = instr_in[24:20];
    assign f7     = instr_in[31:25];

    assign imm_i = {{20{instr_in[31]}}, instr_in[31:20]};
    assign imm_b = {{19{instr_in[31]}}, instr_in[31], instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
    assign imm_u = {instr_in[31:12], 12'd0};
    assign imm_j = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};

    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2];

    // Anything not matched below falls through as a NOP: no write, sequential PC.
    always_comb begin
        alu_op = ALU_ADD;
        alu_b  = rs2_val;
        wb_en  = 1'b0;
        wb_sel = WB_ALU;
        pc_sel = PC_SEQ;
        case (opcode)
            OP_LUI: begin
                wb_en  = 1'b1;
                wb_sel = WB_LUI;
            end
            OP_AUIPC: begin
                wb_en  = 1'b1;
                wb_sel = WB_AUIPC;
            end
            OP_JAL: begin
                wb_en  = 1'b1;
                wb_sel = WB_PC4;
                pc_sel = PC_JAL;
            end
            OP_JALR: begin
                if (f3 == 3'b000) begin
                    alu_b  = imm_i;
                    wb_en  = 1'b1;
                    wb_sel = WB_PC4;
                    pc_sel = PC_JALR;
                end
            end
            OP_BRANCH: begin
                if (f3 != 3'b010 && f3 != 3'b011)
                    pc_sel = PC_BR;
            end
            OP_IMM: begin
                alu_b  = imm_i;
                alu_op = alu_op_from_f3(f3, (f3 == F3_SR) && f7[5]);
                if (f3 == F3_SLL)
                    wb_en = (f7 == F7_BASE);
                else if (f3 == F3_SR)
                    wb_en = (f7 == F7_BASE) || (f7 == F7_ALT);
                else
                    wb_en = 1'b1;
            end
            OP_REG: begin
                alu_op = alu_op_from_f3(f3, f7[5]);
                wb_en  = (f7 == F7_BASE) || ((f7 == F7_ALT) && (f3 == F3_ADD || f3 == F3_SR));
            end
            default: ;
        endcase
    end

    cpu_alu u_alu (
        .op     (alu_op),
        .a      (rs1_val),
        .b      (alu_b),
        .result (alu_result),
        .eq     (alu_eq),
        .lt     (alu_lt),
        .ltu    (alu_ltu)
    );

    always_comb begin
        br_taken = 1'b0;
        case (f3)
            F3_BEQ:  br_taken = alu_eq;
            F3_BNE:  br_taken = !alu_eq;
            F3_BLT:  br_taken = alu_lt;
            F3_BGE:  br_taken = !alu_lt;
            F3_BLTU: br_taken = alu_ltu;
            F3_BGEU: br_taken = !alu_ltu;
            default: br_taken = 1'b0;
        endcase

        wb_data = alu_result;
        case (wb_sel)
            WB_PC4:   wb_data = pc_plus4;
            WB_LUI:   wb_data = imm_u;
            WB_AUIPC: wb_data = pc_q + imm_u;
            default:  wb_data = alu_result;
        endcase

        next_pc = pc_plus4;
        case (pc_sel)
            PC_BR:   next_pc = br_taken ? (pc_q + imm_b) : pc_plus4;
            PC_JAL:  next_pc = pc_q + imm_j;
            PC_JALR: next_pc = alu_result;
            default: next_pc = pc_plus4;
        endcase
    end

    assign wb_write = fire && wb_en && (rd != 5'd0);

    // Targets are word-aligned silently: both low bits dropped, no trap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            addr_vld_q <= 1'b0;
        end else begin
            addr_vld_q <= 1'b1;
            if (fire)
                pc_q <= {next_pc[31:2], 2'b00};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++)
                rf[i] <= 32'd0;
        end else if (wb_write) begin
            rf[rd] <= wb_data;
        end
    end

    assign instr_addr_out       = {pc_q[31:2], 2'b00};
    assign instr_addr_valid_out = addr_vld_q;

`ifdef CPU_DEBUG_PORT_EN
    assign dbg_wb_en   = wb_write;
    assign dbg_wb_addr = wb_write ? rd : 5'd0;
    assign dbg_wb_data = wb_write ? wb_data : 32'd0;
    assign dbg_retire  = fire;
`endif

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: directed RV32I program with a scoreboard of expected rd/PC per fire.
`timescale 1ns/1ps
module tb_cpu;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid_in;
    logic        instr_ready_in;
    logic [31:0] instr_in;
    logic [31:0] instr_addr_out;
    logic        instr_addr_valid_out;
`ifdef CPU_DEBUG_PORT_EN
    logic        dbg_wb_en;
    logic [4:0]  dbg_wb_addr;
    logic [31:0] dbg_wb_data;
    logic        dbg_retire;
`endif

    always #5 clk = ~clk;

    cpu dut (
        .clk                  (clk),
        .rst                  (rst),
        .instr_valid_in       (instr_valid_in),
        .instr_ready_in       (instr_ready_in),
        .instr_in             (instr_in),
        .instr_addr_out       (instr_addr_out),
`ifdef CPU_DEBUG_PORT_EN
        .dbg_wb_en            (dbg_wb_en),
        .dbg_wb_addr          (dbg_wb_addr),
        .dbg_wb_data          (dbg_wb_data),
        .dbg_retire           (dbg_retire),
`endif
        .instr_addr_valid_out (instr_addr_valid_out)
    );

    typedef struct {
        int          rd;
        logic [31:0] val;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] OPC_REG = 7'b0110011;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] xreg(input int i);
        return dut.rf[i];
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                          input logic [2:0] f3, input int rd);
        logic [4:0] a, b, d;
        a = 5'(rs1); b = 5'(rs2); d = 5'(rd);
        return {f7, b, a, f3, d, OPC_REG};
    endfunction

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                          input int rd, input logic [6:0] op);
        logic [11:0] im;
        logic [4:0]  a, d;
        im = 12'(imm); a = 5'(rs1); d = 5'(rd);
        return {im, a, f3, d, op};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input logic [2:0] f3);
        logic [12:0] im;
        logic [4:0]  a, b;
        im = 13'(imm); a = 5'(rs1); b = 5'(rs2);
        return {im[12], im[10:5], b, a, f3, im[4:1], im[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [20:0] im;
        logic [4:0]  d;
        im = 21'(imm); d = 5'(rd);
        return {im[20], im[10:1], im[11], im[19:12], d, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_u(input int imm20, input int rd, input logic [6:0] op);
        logic [19:0] im;
        logic [4:0]  d;
        im = 20'(imm20); d = 5'(rd);
        return {im, d, op};
    endfunction

    task automatic exec(input string tag, input logic [31:0] ins, input int rd,
                        input logic [31:0] val, input logic [31:0] npc);
        exp_t e;
        @(negedge clk);
        instr_in       = ins;
        instr_valid_in = 1'b1;
        instr_ready_in = 1'b1;
        sb.push_back('{rd, val, npc});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".pc"}, instr_addr_out, e.pc);
        check({tag, ".rd"}, xreg(e.rd), e.val);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b0;
        instr_valid_in = 1'b0;
        instr_ready_in = 1'b0;
        instr_in       = 32'd0;
        #30;
        check("rst.pc", instr_addr_out, 32'h0);
        check("rst.vld", {31'd0, instr_addr_valid_out}, 32'h0);
        for (int i = 0; i < 32; i++)
            check($sformatf("rst.x%0d", i), xreg(i), 32'h0);

        instr_in       = 32'h00500093;
        instr_valid_in = 1'b1;
        instr_ready_in = 1'b1;
        rst            = 1'b1;
        @(posedge clk);
        #1;
        check("rel.vld", {31'd0, instr_addr_valid_out}, 32'h1);
        check("rel.pc", instr_addr_out, 32'h0);
        check("rel.x1", xreg(1), 32'h0);

        exec("addi1a", 32'h00500093, 1, 32'h5, 32'h4);
        exec("addi1b", 32'h00500093, 1, 32'h5, 32'h8);
        exec("addi2", 32'hFFD00113, 2, 32'hFFFF_FFFD, 32'hC);
        check("addi2.x1", xreg(1), 32'h5);

        @(negedge clk);
        instr_valid_in = 1'b0;
        instr_in       = enc_i(99, 0, 3'b000, 2, OPC_IMM);
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin
                @(negedge clk);
                instr_valid_in = 1'b1;
                instr_ready_in = 1'b0;
            end
            @(posedge clk);
            #1;
            check($sformatf("stall%0d.pc", c), instr_addr_out, 32'hC);
            check($sformatf("stall%0d.x2", c), xreg(2), 32'hFFFF_FFFD);
        end

        exec("x2eq5", enc_i(5, 0, 3'b000, 2, OPC_IMM), 2, 32'h5, 32'h10);
        exec("bne",   enc_b(8, 2, 1, 3'b001), 1, 32'h5, 32'h14);
        exec("beq",   enc_b(8, 2, 1, 3'b000), 1, 32'h5, 32'h1C);
        exec("x0wr",  enc_i(7, 0, 3'b000, 0, OPC_IMM), 0, 32'h0, 32'h20);
        exec("jal",   enc_j(16, 1), 1, 32'h24, 32'h30);
        exec("addi3", enc_i(-8, 0, 3'b000, 3, OPC_IMM), 3, 32'hFFFF_FFF8, 32'h34);
        exec("add",   enc_r(7'h00, 3, 1, 3'b000, 4), 4, 32'h1C, 32'h38);
        exec("sub",   enc_r(7'h20, 1, 3, 3'b000, 5), 5, 32'hFFFF_FFD4, 32'h3C);
        exec("slt",   enc_r(7'h00, 1, 3, 3'b010, 6), 6, 32'h1, 32'h40);
        exec("sltu",  enc_r(7'h00, 1, 3, 3'b011, 7), 7, 32'h0, 32'h44);
        exec("sra",   enc_r(7'h20, 2, 3, 3'b101, 8), 8, 32'hFFFF_FFFF, 32'h48);
        exec("srl",   enc_r(7'h00, 2, 3, 3'b101, 9), 9, 32'h07FF_FFFF, 32'h4C);
        exec("sll",   enc_r(7'h00, 2, 1, 3'b001, 10), 10, 32'h480, 32'h50);
        exec("xor",   enc_r(7'h00, 3, 1, 3'b100, 11), 11, 32'hFFFF_FFDC, 32'h54);
        exec("or",    enc_r(7'h00, 2, 1, 3'b110, 12), 12, 32'h25, 32'h58);
        exec("and",   enc_r(7'h00, 1, 3, 3'b111, 13), 13, 32'h20, 32'h5C);
        exec("slti",  enc_i(-7, 3, 3'b010, 14, OPC_IMM), 14, 32'h1, 32'h60);
        exec("sltiu", enc_i(-1, 1, 3'b011, 15, OPC_IMM), 15, 32'h1, 32'h64);
        exec("xori",  enc_i(32'hFF, 1, 3'b100, 16, OPC_IMM), 16, 32'hDB, 32'h68);
        exec("ori",   enc_i(32'h100, 1, 3'b110, 17, OPC_IMM), 17, 32'h124, 32'h6C);
        exec("andi",  enc_i(32'h7F0, 3, 3'b111, 18, OPC_IMM), 18, 32'h7F0, 32'h70);
        exec("slli",  enc_i(3, 2, 3'b001, 19, OPC_IMM), 19, 32'h28, 32'h74);
        exec("srli",  enc_i(28, 3, 3'b101, 20, OPC_IMM), 20, 32'hF, 32'h78);
        exec("srai",  enc_i(32'h402, 3, 3'b101, 21, OPC_IMM), 21, 32'hFFFF_FFFE, 32'h7C);
        exec("lui",   enc_u(32'h12345, 22, 7'b0110111), 22, 32'h1234_5000, 32'h80);
        exec("auipc", enc_u(32'h1, 23, 7'b0010111), 23, 32'h1080, 32'h84);
        exec("blt",   enc_b(8, 1, 3, 3'b100), 3, 32'hFFFF_FFF8, 32'h8C);
        exec("bltu",  enc_b(8, 1, 3, 3'b110), 3, 32'hFFFF_FFF8, 32'h90);
        exec("bge",   enc_b(-16, 3, 1, 3'b101), 1, 32'h24, 32'h80);
        exec("bgeu",  enc_b(8, 3, 1, 3'b111), 1, 32'h24, 32'h84);
        exec("jalr",  enc_i(3, 1, 3'b000, 24, 7'b1100111), 24, 32'h88, 32'h24);
        exec("badf7", enc_r(7'h01, 2, 1, 3'b000, 25), 25, 32'h0, 32'h28);
        exec("load",  enc_i(0, 1, 3'b010, 26, 7'b0000011), 26, 32'h0, 32'h2C);
        exec("bslli", enc_i(32'h403, 2, 3'b001, 27, OPC_IMM), 27, 32'h0, 32'h30);

        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst.pc", instr_addr_out, 32'h0);
        check("arst.vld", {31'd0, instr_addr_valid_out}, 32'h0);
        check("arst.x1", xreg(1), 32'h0);
        check("arst.x24", xreg(24), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rerel.vld", {31'd0, instr_addr_valid_out}, 32'h1);
        exec("resume", 32'h00500093, 1, 32'h5, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
